// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-3 demultiplexer: select encodings
// and error-counter sizing.
package demux_pkg;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  localparam int              ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/demux1_3_buf_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count; one per
// output channel of demux1_3_buf.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage is cleared on reset so the head data reads 0 until
      // the first write; drop this loop if reset-free RAM is ever needed.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so push and pop in one cycle see the same count.
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux1_3_buf.sv
// Buffered 1-to-3 stream demultiplexer: steers each beat into one of three
// independently back-pressured FIFOs; select 3 drops the beat and counts it.
module demux1_3_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic             out_valid_a,
  output logic             out_valid_b,
  output logic             out_valid_c,
  input  logic             out_ready_a,
  input  logic             out_ready_b,
  input  logic             out_ready_c,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse
);

  logic [2:0]       push, pop, full, empty;
  logic [WIDTH-1:0] head [3];
  logic             accept, drop;

  // in_ready looks only at fullness, never at out_ready, so a full FIFO
  // cannot take a beat even if its consumer pops in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise
    // the incomplete case would infer latches.
    in_ready = 1'b1;
    case (in_sel)
      SEL_A:   in_ready = ~full[0];
      SEL_B:   in_ready = ~full[1];
      SEL_C:   in_ready = ~full[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & (in_sel == SEL_BAD);

  always_comb begin
    push = '0;
    case (in_sel)
      SEL_A:   push[0] = accept;
      SEL_B:   push[1] = accept;
      SEL_C:   push[2] = accept;
      default: push    = '0;
    endcase
  end

  assign pop = ~empty & {out_ready_c, out_ready_b, out_ready_a};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[g]),
      .pop     (pop[g]),
      .wr_data (in_data),
      .rd_data (head[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  assign out_data_a  = head[0];
  assign out_data_b  = head[1];
  assign out_data_c  = head[2];
  assign out_valid_a = ~empty[0];
  assign out_valid_b = ~empty[1];
  assign out_valid_c = ~empty[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= drop;
      if (drop && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: doc/demux1_3_buf.md
# demux1_3_buf

Buffered 1-to-3 stream demultiplexer: the routing counterpart of the 3:1 byte selector. It accepts one 8-bit beat per cycle with a 2-bit destination select and steers each beat into one of three independently back-pressured output channels (A, B, C). Each channel has its own small FIFO, so a stalled consumer blocks only beats addressed to it. Select value 3 is illegal; beats carrying it are dropped and counted.

## Interface
- WIDTH, 8: data width of every channel.
- DEPTH, 2: entries per output FIFO; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  WIDTH  input beat.
- in_sel  in  2  destination: 0=A, 1=B, 2=C, 3=illegal.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can take the beat on in_data/in_sel.
- out_data_a / out_data_b / out_data_c  out  WIDTH  head of each channel FIFO.
- out_valid_a / out_valid_b / out_valid_c  out  1  channel FIFO non-empty.
- out_ready_a / out_ready_b / out_ready_c  in  1  consumer takes head beat.
- err_cnt  out  8  dropped illegal beats, saturating at 255.
- err_pulse  out  1  one-cycle pulse, the cycle after an illegal beat is dropped.

## Operation
- Accept = in_valid & in_ready. Pop on channel X = out_valid_X & out_ready_X.
- in_ready is combinational: 1 when in_sel=3; otherwise !full of the FIFO selected by in_sel. It must not depend on any out_ready (no same-cycle pass-through into a full FIFO).
- Accepted beat with in_sel 0/1/2 is written at wr_ptr of that FIFO; wr_ptr increments mod DEPTH; count increments.
- Accepted beat with in_sel=3: nothing written; err_cnt += 1 unless already 255; err_pulse=1 next cycle.
- Each FIFO: count 0..DEPTH, rd_ptr/wr_ptr wrap mod DEPTH. Implied states EMPTY (count 0), PARTIAL, FULL (count DEPTH).
- First-word fall-through: out_valid_X = (count_X≠0); out_data_X = mem_X[rd_ptr_X].
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. Possible only when not FULL before the edge.
- Pop on EMPTY is impossible (valid low). Push on FULL is impossible (in_ready low).
- Per-channel order preserved. No ordering guarantee across channels.
- in_sel is ignored while in_valid=0; in_ready may toggle with it.

## Timing
- Reset (rst_n=0 at an edge): all counts and pointers 0; FIFO memories 0; out_valid_* 0; out_data_* 0; err_cnt 0; err_pulse 0. in_ready after reset = 1 for every in_sel.
- Reset mid-operation discards all buffered beats; it has priority over a same-cycle accept or pop.
- Latency: beat accepted at edge N → out_valid_X=1 with that data in the cycle following edge N (1 cycle), if the FIFO was empty.
- Throughput: one beat per cycle sustained into any channel whose consumer holds out_ready=1.
- err_pulse asserts for exactly the cycle after each dropped beat; back-to-back drops give a continuous high.

## Structure
- Shared package demux_pkg: SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_BAD=2'd3; ERR_W=8; ERR_MAX=8'hFF.
- One sub-module: sync_fifo (WIDTH, DEPTH; push, pop, full, empty, head data, synchronous active-low reset). Instantiate it three times. The top level holds the select decode, in_ready mux and error counter.

## Test plan
- Reset then idle: all outputs 0, in_ready=1 for in_sel 0..3.
- Send 8'h11→A, 8'h22→B, 8'h33→C on consecutive cycles with all out_ready=1 → each appears one cycle after acceptance on its own channel; other channels' valid stays 0.
- Hold out_ready_a=0 and send 3 beats to A (DEPTH=2) → first two accepted; in_ready=0 for in_sel=0 on the third while in_sel=1 still shows in_ready=1. Release ready → A drains in order, then the third beat is accepted.
- FIFO A at count 1, push and pop in the same cycle → count stays 1, pointers wrap correctly over 5 iterations, data order intact.
- 260 beats with in_sel=3 → nothing on any output; err_cnt ends at 255; err_pulse high for 260 cycles, each one cycle after its drop.
- Fill B to full, assert rst_n=0 together with in_valid and out_ready_b → next cycle all counts 0, out_valid_b=0, err_cnt=0.
